fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// - Multi-cycle instruction fetch sequencer: owns the PC, reads instruction memory, presents one instruction per step.
// - Presents each instruction to the opcode-decoding control unit.
// - Consumes the decoded jump/halt results and the datapath stall, and selects the next PC.
// - Sits between the instruction ROM and the control unit; it is the producer of the opcode that the control unit consumes.
// PARAMETERS
// - PC_W     10  width of PC / instruction memory address
// - INSTR_W  9   instruction word width; opcode field = instr[INSTR_W-1 -: OPC_W]
// - OPC_W    8   opcode width presented to control unit
// - CNT_W    16  width of retired-instruction counter
// PORTS
// - clk          in   1        single clock; all state changes on rising edge
// - reset        in   1        synchronous, active-high
// - start        in   1        begin execution at PC 0; honoured only in IDLE or HALTED
// - imem_rd_en   out  1        instruction memory read strobe
// - imem_addr    out  PC_W     instruction memory address (= pc)
// - imem_rdata   in   INSTR_W  instruction data, valid the cycle after imem_rd_en
// - instr        out  INSTR_W  registered current instruction
// - opcode       out  OPC_W    opcode field of instr, to control unit
// - instr_valid  out  1        high for every cycle in EXEC
// - jump         in   1        from control unit; sampled in EXEC only
// - jump_target  in   PC_W     absolute target; used when jump taken
// - halt         in   1        decoded halt; sampled in EXEC only
// - stall        in   1        datapath busy; holds the current instruction in EXEC
// - pc           out  PC_W     current program counter
// - busy         out  1        high in FETCH/LOAD/EXEC
// - done         out  1        level, high in HALTED
// - icount       out  CNT_W    retired-instruction count, wraps modulo 2^CNT_W
// BEHAVIOUR
// - Reset (from any state, including mid-instruction) -> IDLE on the next edge.
//   - Reset values: pc=0, instr=0, imem_rd_en=0, instr_valid=0, busy=0, done=0, icount=0.
// - FSM: IDLE, FETCH, LOAD, EXEC, HALTED.
//   - IDLE: start=1 -> FETCH; pc<=0, icount<=0.
//   - FETCH: imem_rd_en=1, imem_addr=pc; -> LOAD.
//   - LOAD: instr<=imem_rdata at the edge; -> EXEC.
//   - EXEC: instr_valid=1. Decision priority is stall > halt > jump > sequential.
//     - stall=1: remain in EXEC; pc and instr unchanged; jump/halt ignored this cycle.
//     - halt=1: retire (icount+1), pc held, -> HALTED.
//     - jump=1: retire, pc<=jump_target, -> FETCH.
//     - otherwise: retire, pc<=pc+1, -> FETCH.
//   - HALTED: done=1; start=1 -> FETCH with pc<=0, icount<=0, done cleared.
// - Latency: start seen at edge N -> FETCH in cycle N+1, instr_valid in cycle N+3.
//   - Unstalled throughput is one instruction per 3 cycles.
// - Arithmetic: pc+1 wraps modulo 2^PC_W (max -> 0), with no flag; icount wraps silently.
// - start outside IDLE/HALTED is ignored. jump/halt/stall outside EXEC are ignored.
// - imem_rd_en is asserted only in FETCH; imem_addr always equals pc.
// - Outputs are registered or decoded from state only; no combinational path from inputs to outputs.
// STRUCTURE
// - Package fetch_pkg: fetch_state_t enum {IDLE,FETCH,LOAD,EXEC,HALTED}, default PC_W/INSTR_W/OPC_W constants.
// - Sub-module program_counter: PC register with clear, load(target), increment (wrapping), hold.
//   - Its controls are driven by the FSM.
// - FSM, instruction register and icount live in fetch_unit.
// TESTING
// - Reset, then start pulse at cycle 0, ROM[i]=i:
//   - imem_addr 0,1,2 in cycles 1,4,7.
//   - instr_valid in cycles 3,6,9 with instr=0,1,2.
//   - icount=3 after cycle 9.
// - jump=1, jump_target=0x040 in EXEC at pc=5: next FETCH imem_addr=0x040, icount incremented by 1.
// - stall=1 for 4 EXEC cycles at pc=2, with jump=1 in the 2nd stalled cycle:
//   - instr_valid high 5 cycles; jump ignored.
//   - next fetch addr=3.
// - halt=1 in EXEC at pc=7 from a fresh start:
//   - next cycle done=1, busy=0, pc=7, icount=8.
//   - start=1 -> done=0, next FETCH addr=0, icount=0.
// - PC_W=4, sequential code reaching pc=15: next FETCH imem_addr=0.
// - reset asserted during LOAD: next cycle all outputs at reset values, state IDLE; later start fetches addr 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch sequencer.
package fetch_pkg;

    // Sequencer states: one instruction takes FETCH -> LOAD -> EXEC.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        EXEC   = 3'd3,
        HALTED = 3'd4
    } fetch_state_t;

    localparam int DEF_PC_W    = 10;
    localparam int DEF_INSTR_W = 9;
    localparam int DEF_OPC_W   = 8;
    localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/program_counter.sv
// Program counter register: clear, absolute load, wrapping increment, hold.
module program_counter #(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_clear,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_target,
    input  logic            i_inc,
    output logic [PC_W-1:0] o_pc
);

    logic [PC_W-1:0] r_pc;

    // Clear wins over load, load wins over increment; otherwise hold.
    // Increment wraps from all-ones back to zero with no flag.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_pc <= '0;
        end else if (i_load) begin
            r_pc <= i_target;
        end else if (i_inc) begin
            r_pc <= r_pc + PC_W'(1);
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Multi-cycle instruction fetch sequencer. Owns the PC, reads the
// instruction ROM, holds the current instruction for the control unit and
// picks the next PC from the decoded jump/halt results and the stall.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int OPC_W   = DEF_OPC_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               imem_rd_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [OPC_W-1:0]   opcode,
    output logic               instr_valid,
    input  logic               jump,
    input  logic [PC_W-1:0]    jump_target,
    input  logic               halt,
    input  logic               stall,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   icount
);

    fetch_state_t       r_state;
    logic [INSTR_W-1:0] r_instr;
    logic [CNT_W-1:0]   r_icount;
    logic               r_imem_rd_en;
    logic               r_instr_valid;
    logic               r_busy;
    logic               r_done;

    logic               w_pc_clear;
    logic               w_pc_load;
    logic               w_pc_inc;
    logic [PC_W-1:0]    w_pc;

    // PC controls: a start from IDLE/HALTED restarts at 0; in EXEC an
    // unstalled, non-halting instruction either jumps or steps by one.
    // A halt keeps the PC pointing at the halting instruction.
    always_comb begin
        w_pc_clear = 1'b0;
        w_pc_load  = 1'b0;
        w_pc_inc   = 1'b0;
        case (r_state)
            IDLE, HALTED: w_pc_clear = start;
            EXEC: begin
                if (!stall && !halt) begin
                    if (jump) begin
                        w_pc_load = 1'b1;
                    end else begin
                        w_pc_inc = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    program_counter #(
        .PC_W (PC_W)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_pc_clear),
        .i_load   (w_pc_load),
        .i_target (jump_target),
        .i_inc    (w_pc_inc),
        .o_pc     (w_pc)
    );

    // Sequencer FSM. Status outputs are registered and set for the state
    // being entered, so they never depend combinationally on inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_instr       <= '0;
            r_icount      <= '0;
            r_imem_rd_en  <= 1'b0;
            r_instr_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state      <= FETCH;
                        r_icount     <= '0;
                        r_imem_rd_en <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                FETCH: begin
                    // ROM answers one cycle after the strobe.
                    r_state      <= LOAD;
                    r_imem_rd_en <= 1'b0;
                end
                LOAD: begin
                    r_state       <= EXEC;
                    r_instr       <= imem_rdata;
                    r_instr_valid <= 1'b1;
                end
                EXEC: begin
                    // Stall freezes everything, so jump/halt are only
                    // acted on in the cycle the instruction retires.
                    if (!stall) begin
                        r_icount      <= r_icount + CNT_W'(1);
                        r_instr_valid <= 1'b0;
                        if (halt) begin
                            r_state <= HALTED;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state      <= FETCH;
                            r_imem_rd_en <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    if (start) begin
                        r_state      <= FETCH;
                        r_icount     <= '0;
                        r_done       <= 1'b0;
                        r_busy       <= 1'b1;
                        r_imem_rd_en <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_imem_rd_en  <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_busy        <= 1'b0;
                    r_done        <= 1'b0;
                end
            endcase
        end
    end

    assign imem_rd_en  = r_imem_rd_en;
    assign imem_addr   = w_pc;
    assign pc          = w_pc;
    assign instr       = r_instr;
    assign opcode      = r_instr[INSTR_W-1 -: OPC_W];
    assign instr_valid = r_instr_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign icount      = r_icount;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential flow, jump, stall, halt/restart,
// reset mid-instruction and PC wrap on a narrow-PC instance.
module tb_fetch_unit;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;
    localparam int OPC_W   = 8;
    localparam int CNT_W   = 16;
    localparam int PC4_W   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic               start;
    logic               imem_rd_en;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr;
    logic [OPC_W-1:0]   opcode;
    logic               instr_valid;
    logic               jump;
    logic [PC_W-1:0]    jump_target;
    logic               halt;
    logic               stall;
    logic [PC_W-1:0]    pc;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   icount;

    logic               start4;
    logic               imem_rd_en4;
    logic [PC4_W-1:0]   imem_addr4;
    logic [INSTR_W-1:0] imem_rdata4;
    logic [INSTR_W-1:0] instr4;
    logic [OPC_W-1:0]   opcode4;
    logic               instr_valid4;
    logic [PC4_W-1:0]   pc4;
    logic               busy4;
    logic               done4;
    logic [CNT_W-1:0]   icount4;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(
        .PC_W(PC_W), .INSTR_W(INSTR_W), .OPC_W(OPC_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
        .jump(jump), .jump_target(jump_target), .halt(halt), .stall(stall),
        .pc(pc), .busy(busy), .done(done), .icount(icount)
    );

    fetch_unit #(
        .PC_W(PC4_W), .INSTR_W(INSTR_W), .OPC_W(OPC_W), .CNT_W(CNT_W)
    ) dut4 (
        .clk(clk), .reset(reset), .start(start4),
        .imem_rd_en(imem_rd_en4), .imem_addr(imem_addr4), .imem_rdata(imem_rdata4),
        .instr(instr4), .opcode(opcode4), .instr_valid(instr_valid4),
        .jump(1'b0), .jump_target(4'd0), .halt(1'b0), .stall(1'b0),
        .pc(pc4), .busy(busy4), .done(done4), .icount(icount4)
    );

    // ROM models with ROM[i] = i, one-cycle registered read.
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= INSTR_W'(imem_addr);
        if (imem_rd_en4) imem_rdata4 <= INSTR_W'(imem_addr4);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({pc, instr, icount} !== '0) begin
            failures++;
            $display("FAIL reset_regs actual pc=%0d instr=%0d icount=%0d required all 0", pc, instr, icount);
        end
        checks++;
        if ({imem_rd_en, instr_valid, busy, done} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags actual rd_en/valid/busy/done=%b required 0000",
                     {imem_rd_en, instr_valid, busy, done});
        end
        tick();
    endtask

    task automatic test_sequential;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (imem_rd_en !== 1'b1 || imem_addr !== PC_W'(i) || busy !== 1'b1) begin
                failures++;
                $display("FAIL seq_fetch%0d actual rd_en=%b addr=%0d busy=%b required 1 %0d 1",
                         i, imem_rd_en, imem_addr, busy, i);
            end
            tick();
            tick();
            checks++;
            if (instr_valid !== 1'b1 || instr !== INSTR_W'(i) || opcode !== OPC_W'(i >> 1)) begin
                failures++;
                $display("FAIL seq_exec%0d actual valid=%b instr=%0d opcode=%0d required 1 %0d %0d",
                         i, instr_valid, instr, opcode, i, i >> 1);
            end
            tick();
            if (i == 2) begin
                checks++;
                if (icount !== CNT_W'(3)) begin
                    failures++;
                    $display("FAIL seq_icount actual=%0d required=3", icount);
                end
            end
        end
    endtask

    task automatic test_jump;
        // start while busy must not restart the sequence
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr !== INSTR_W'(5) || pc !== PC_W'(5)) begin
            failures++;
            $display("FAIL jump_pre actual valid=%b instr=%0d pc=%0d required 1 5 5", instr_valid, instr, pc);
        end
        jump = 1'b1;
        jump_target = 10'h040;
        tick();
        jump = 1'b0;
        jump_target = '0;
        checks++;
        if (imem_rd_en !== 1'b1 || imem_addr !== 10'h040 || icount !== CNT_W'(6)) begin
            failures++;
            $display("FAIL jump_target actual rd_en=%b addr=%0h icount=%0d required 1 40 6",
                     imem_rd_en, imem_addr, icount);
        end
        tick();
        tick();
        checks++;
        if (instr !== INSTR_W'(64)) begin
            failures++;
            $display("FAIL jump_instr actual=%0d required=64", instr);
        end
        tick();
        checks++;
        if (imem_addr !== 10'h041) begin
            failures++;
            $display("FAIL jump_next actual=%0h required=41", imem_addr);
        end
    endtask

    task automatic test_halt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            tick();
            tick();
        end
        tick();
        tick();
        checks++;
        if (pc !== PC_W'(7) || instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL halt_pre actual pc=%0d valid=%b required 7 1", pc, instr_valid);
        end
        halt = 1'b1;
        tick();
        halt = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pc !== PC_W'(7) || icount !== CNT_W'(8) || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL halt_state actual done=%b busy=%b pc=%0d icount=%0d valid=%b required 1 0 7 8 0",
                     done, busy, pc, icount, instr_valid);
        end
        tick();
        checks++;
        if (done !== 1'b1 || imem_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL halt_hold actual done=%b rd_en=%b required 1 0", done, imem_rd_en);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || imem_rd_en !== 1'b1 || imem_addr !== '0 || icount !== '0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL halt_restart actual done=%b rd_en=%b addr=%0d icount=%0d busy=%b required 0 1 0 0 1",
                     done, imem_rd_en, imem_addr, icount, busy);
        end
    endtask

    task automatic test_stall;
        int valid_cnt;
        valid_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            tick();
            tick();
        end
        tick();
        tick();
        stall = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            jump = (k == 2);
            jump_target = 10'h3FF;
            if (instr_valid === 1'b1) valid_cnt++;
            checks++;
            if (pc !== PC_W'(2) || instr !== INSTR_W'(2)) begin
                failures++;
                $display("FAIL stall_hold%0d actual pc=%0d instr=%0d required 2 2", k, pc, instr);
            end
            tick();
        end
        stall = 1'b0;
        jump = 1'b0;
        jump_target = '0;
        if (instr_valid === 1'b1) valid_cnt++;
        tick();
        checks++;
        if (valid_cnt != 5 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_valid actual cycles=%0d valid_after=%b required 5 0", valid_cnt, instr_valid);
        end
        checks++;
        if (imem_rd_en !== 1'b1 || imem_addr !== PC_W'(3) || icount !== CNT_W'(3)) begin
            failures++;
            $display("FAIL stall_next actual rd_en=%b addr=%0d icount=%0d required 1 3 3",
                     imem_rd_en, imem_addr, icount);
        end
    endtask

    task automatic test_reset_during_load;
        tick();
        checks++;
        if (imem_rd_en !== 1'b0 || instr_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rl_load actual rd_en=%b valid=%b busy=%b required 0 0 1", imem_rd_en, instr_valid, busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({pc, instr, icount} !== '0 || {imem_rd_en, instr_valid, busy, done} !== 4'b0000) begin
            failures++;
            $display("FAIL rl_reset actual pc=%0d instr=%0d icount=%0d flags=%b required 0 0 0 0000",
                     pc, instr, icount, {imem_rd_en, instr_valid, busy, done});
        end
        tick();
        checks++;
        if (busy !== 1'b0 || imem_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL rl_idle actual busy=%b rd_en=%b required 0 0", busy, imem_rd_en);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (imem_rd_en !== 1'b1 || imem_addr !== '0) begin
            failures++;
            $display("FAIL rl_restart actual rd_en=%b addr=%0d required 1 0", imem_rd_en, imem_addr);
        end
        tick();
        tick();
        checks++;
        if (instr_valid !== 1'b1 || instr !== '0) begin
            failures++;
            $display("FAIL rl_exec actual valid=%b instr=%0d required 1 0", instr_valid, instr);
        end
    endtask

    task automatic test_pc_wrap;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 0 || i == 15) begin
                checks++;
                if (imem_rd_en4 !== 1'b1 || imem_addr4 !== PC4_W'(i)) begin
                    failures++;
                    $display("FAIL wrap_fetch%0d actual rd_en=%b addr=%0d required 1 %0d",
                             i, imem_rd_en4, imem_addr4, i);
                end
            end
            tick();
            tick();
            tick();
        end
        checks++;
        if (imem_rd_en4 !== 1'b1 || imem_addr4 !== '0 || icount4 !== CNT_W'(16)) begin
            failures++;
            $display("FAIL wrap_zero actual rd_en=%b addr=%0d icount=%0d required 1 0 16",
                     imem_rd_en4, imem_addr4, icount4);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        start4 = 1'b0;
        jump = 1'b0;
        jump_target = '0;
        halt = 1'b0;
        stall = 1'b0;
        test_reset();
        test_sequential();
        test_jump();
        test_halt();
        test_stall();
        test_reset_during_load();
        test_pc_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
